wishbone_config_loader: RTL and testbench
=========================================

Name: wishbone_config_loader

Overview:
Wishbone classic master that drives the configuration slave over its register interface. It takes a byte stream from an upstream source (UART/SPI front end) and issues three kinds of write transaction:
- control word to BASE+1
- N data words to BASE+2
- commit write of 1 to BASE+0
It replaces bench-driven or firmware-driven bus sequences with an autonomous hardware loader.

Parameters:
BASE_ADDR, 32'h3000_0000, base address of the configuration slave
CTRL_OFFSET, 1, word offset of the control register
DATA_OFFSET, 2, word offset of the shift-data register
COMMIT_OFFSET, 0, word offset of the commit register
TIMEOUT_CYCLES, 256, maximum cycles to wait for ack (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a load when idle
s_data  in  8  stream byte
s_valid  in  1  stream byte valid
s_ready  out  1  loader accepts byte (transfer when s_valid&s_ready)
wbm_cyc_o  out  1  bus cycle
wbm_stb_o  out  1  strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte select, always 4'hF when stb
wbm_addr_o  out  32  address
wbm_data_o  out  32  write data
wbm_data_i  in  32  read data (unused, ignored)
wbm_ack_i  in  1  slave acknowledge
busy  out  1  load in progress
done  out  1  one-cycle pulse on commit ack
error  out  1  one-cycle pulse on bus timeout
words_written  out  16  data words acked in current/last load

Behaviour:
- Reset: all outputs 0 (addr/data 0); state IDLE; words_written 0. Reset mid-transaction drops cyc/stb at the next edge; the load is abandoned and no done is issued.
- Word assembly: bytes are MSB-first; the first byte lands in [31:24].
- Length field: 2 bytes, MSB-first, giving N.
- All outputs are registered.
- States:
  - IDLE: s_ready=0, busy=0; start -> GET_CTRL. start while busy is ignored.
  - GET_CTRL: s_ready=1; after 4 bytes -> WR_CTRL.
  - WR_CTRL: addr=BASE_ADDR+CTRL_OFFSET; on ack -> GET_LEN.
  - GET_LEN: accepts 2 bytes into N; N=0 -> WR_COMMIT, else -> GET_DATA.
  - GET_DATA: accepts 4 bytes -> WR_DATA.
  - WR_DATA: addr=BASE_ADDR+DATA_OFFSET; on ack, words_written++. If words_written (post-increment) equals N -> WR_COMMIT, else -> GET_DATA.
  - WR_COMMIT: addr=BASE_ADDR+COMMIT_OFFSET, data=32'h1; on ack, done=1 for one cycle -> IDLE.
- s_ready is 0 in every WR_* state; the stream stalls, no bytes are lost.
- Bus handshake:
  - On entering a WR_* state, cyc=stb=we=1 and sel=4'hF are asserted with addr/data stable.
  - All are held until ack is sampled high; they are deasserted on the following edge.
  - At least one idle bus cycle separates transactions.
  - ack while stb=0 is ignored.
  - ack and s_valid in the same cycle cannot conflict (s_ready=0).
- words_written is cleared on start and holds its value after done until the next start.
- N wraps at 16 bits; maximum 65535 words.

Optional Feature:
Macro WB_CONFIG_LOADER_TIMEOUT_EN.
- Defined:
  - A counter resets on each stb rising and increments while stb=1 and ack=0.
  - On reaching TIMEOUT_CYCLES: cyc/stb drop next edge, error pulses one cycle, state -> IDLE, no done.
- Undefined: waits for ack indefinitely; error tied to 0; the counter is not instantiated.

Decomposition:
- Package wb_config_loader_pkg:
  - state enum encodings
  - offset constants CTRL_OFFSET/DATA_OFFSET/COMMIT_OFFSET defaults
  - SEL_ALL=4'hF
  - COMMIT_VALUE=32'h1
- Sub-module wb_master_single: issues one write transaction (req/addr/data in; ack_done/timeout out), containing the handshake and the optional timeout counter. The top holds the byte-assembly FSM.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 03 04 05 FF, 00 02, 0F AA 55 F0, F0 55 AA 0F, with a slave acking 1 cycle after stb.
  - Required response, in order:
    - write 3000_0001 <= 0304_05FF
    - write 3000_0002 <= 0FAA_55F0
    - write 3000_0002 <= F055_AA0F
    - write 3000_0000 <= 1
  - Then done pulses once and words_written=2.
- N=0:
  - Stimulus: start, then bytes 00 00 00 01, 00 00.
  - Required response: control write, then commit write directly; no BASE+2 access; words_written=0.
- Slow slave and stream backpressure:
  - Stimulus: ack delayed 7 cycles; s_valid held high.
  - Required response: s_ready=0 throughout each WR_*; every byte is consumed exactly once; stb is held stable for 7 cycles.
- Reset mid-load:
  - Stimulus: assert wb_rst_i during the second WR_DATA.
  - Required response: cyc/stb=0 the next cycle; busy=0; no done. A subsequent full load succeeds.
- Timeout (macro defined, TIMEOUT_CYCLES=16):
  - Stimulus: slave never acks.
  - Required response: error pulse exactly 16 cycles after stb; bus released; returns to IDLE.
- Spurious ack:
  - Stimulus: ack pulsed while in IDLE, and again during GET_DATA.
  - Required response: no state change and no count change.

Source files
------------

// File: rtl/wb_config_loader_pkg.sv
// wb_config_loader_pkg
// Shared definitions for the Wishbone configuration loader:
//   - state_t         : loader FSM states
//   - DEF_*_OFFSET    : default word offsets of the slave's registers
//   - SEL_ALL         : byte-select value driven with every strobe
//   - COMMIT_VALUE    : value written to the commit register
//   - is_wr_state()   : true for states that own a bus transaction
package wb_config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CTRL,
    ST_WR_CTRL,
    ST_GET_LEN,
    ST_GET_DATA,
    ST_WR_DATA,
    ST_WR_COMMIT
  } state_t;

  localparam logic [31:0] DEF_CTRL_OFFSET   = 32'd1;
  localparam logic [31:0] DEF_DATA_OFFSET   = 32'd2;
  localparam logic [31:0] DEF_COMMIT_OFFSET = 32'd0;

  localparam logic [3:0]  SEL_ALL      = 4'hF;
  localparam logic [31:0] COMMIT_VALUE = 32'h1;

  function automatic logic is_wr_state(input state_t s);
    return (s == ST_WR_CTRL) || (s == ST_WR_DATA) || (s == ST_WR_COMMIT);
  endfunction

endpackage

// File: rtl/wb_master_single.sv
// wb_master_single
// Issues one Wishbone classic write per request and holds it until the
// slave acknowledges (or, optionally, until a wait limit expires).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req               : start a write (only honoured while no write is open)
//   addr_i, data_i    : address/data captured when req is honoured
//   ack_i             : slave acknowledge (ignored while stb is low)
//   cyc_o..data_o     : registered Wishbone master outputs
//   ack_done          : high in the cycle the open write is acknowledged
//   timeout           : high in the cycle the wait limit is reached
// Optional feature: define WB_CONFIG_LOADER_TIMEOUT_EN to enable the
// ack wait counter (TIMEOUT_CYCLES); otherwise timeout is tied low.
module wb_master_single
  import wb_config_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        ack_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic        ack_done,
  output logic        timeout
);

  logic        active_q, active_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  // cyc/stb/we all follow a single flop so they can never disagree.
  assign cyc_o  = active_q;
  assign stb_o  = active_q;
  assign we_o   = active_q;
  assign sel_o  = sel_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

  assign ack_done = active_q & ack_i;

  always_comb begin
    active_d = active_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (active_q) begin
      if (ack_done || timeout) begin
        active_d = 1'b0;
        sel_d    = 4'h0;
      end
    end else if (req) begin
      active_d = 1'b1;
      sel_d    = SEL_ALL;
      addr_d   = addr_i;
      data_d   = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sel_q    <= 4'h0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      active_q <= active_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

`ifdef WB_CONFIG_LOADER_TIMEOUT_EN
  // Counts cycles the strobe has been waiting; cleared as the strobe rises.
  // The limit is hit in the last waiting cycle so the bus drops exactly
  // TIMEOUT_CYCLES edges after the strobe went high.
  logic [31:0] wait_cnt_q, wait_cnt_d;

  assign timeout = active_q & ~ack_i & (wait_cnt_q == (TIMEOUT_CYCLES - 32'd1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!active_q && req) begin
      wait_cnt_d = 32'h0;
    end else if (active_q && !ack_i) begin
      wait_cnt_d = wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 32'h0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/wishbone_config_loader.sv
// wishbone_config_loader
// Autonomous Wishbone master that turns an upstream byte stream into a
// configuration sequence: control word -> BASE+CTRL, N data words ->
// BASE+DATA, then a commit write of 1 -> BASE+COMMIT.
// Stream format (all MSB-first): 4 control bytes, 2 length bytes (N),
// then 4*N data bytes.
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   start              : one-cycle pulse, starts a load when idle
//   s_data/s_valid/s_ready : byte stream handshake
//   wbm_*              : Wishbone classic master (wbm_data_i ignored)
//   busy               : load in progress
//   done               : one-cycle pulse after the commit is acknowledged
//   error              : one-cycle pulse on ack timeout
//   words_written      : data words acknowledged in the current/last load
// Optional feature: define WB_CONFIG_LOADER_TIMEOUT_EN to abandon a load
// when a write waits TIMEOUT_CYCLES without ack; otherwise error stays 0.
module wishbone_config_loader
  import wb_config_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] CTRL_OFFSET    = DEF_CTRL_OFFSET,
  parameter logic [31:0] DATA_OFFSET    = DEF_DATA_OFFSET,
  parameter logic [31:0] COMMIT_OFFSET  = DEF_COMMIT_OFFSET,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] n_q, n_d;
  logic [15:0] words_q, words_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic        req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        ack_done;
  logic        timeout;
  logic        unused_rd_data;

  assign unused_rd_data = ^wbm_data_i;

  assign s_ready       = s_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_q;

  assign accept = s_valid & s_ready_q;

  // A write is requested in the first cycle of each WR_* state while the
  // bus is free; the previous write drops cyc on the edge that enters the
  // state, which guarantees an idle bus cycle between transactions.
  assign req = is_wr_state(state_q) & ~wbm_cyc_o;

  always_comb begin
    req_addr = BASE_ADDR + CTRL_OFFSET;
    req_data = word_q;
    case (state_q)
      ST_WR_DATA:   req_addr = BASE_ADDR + DATA_OFFSET;
      ST_WR_COMMIT: begin
        req_addr = BASE_ADDR + COMMIT_OFFSET;
        req_data = COMMIT_VALUE;
      end
      default: ;
    endcase
  end

  wb_master_single #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_master (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .req      (req),
    .addr_i   (req_addr),
    .data_i   (req_data),
    .ack_i    (wbm_ack_i),
    .cyc_o    (wbm_cyc_o),
    .stb_o    (wbm_stb_o),
    .we_o     (wbm_we_o),
    .sel_o    (wbm_sel_o),
    .addr_o   (wbm_addr_o),
    .data_o   (wbm_data_o),
    .ack_done (ack_done),
    .timeout  (timeout)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    len_hi_d   = len_hi_q;
    n_d        = n_q;
    words_d    = words_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_GET_CTRL;
          byte_cnt_d = 2'd0;
          words_d    = 16'd0;
        end
      end
      // The 2-bit byte counter wraps to 0 on the fourth byte, ready for
      // the next field.
      ST_GET_CTRL, ST_GET_DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], s_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = (state_q == ST_GET_CTRL) ? ST_WR_CTRL : ST_WR_DATA;
          end
        end
      end
      ST_WR_CTRL: begin
        if (ack_done) state_d = ST_GET_LEN;
      end
      ST_GET_LEN: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            len_hi_d   = s_data;
            byte_cnt_d = 2'd1;
          end else begin
            n_d        = {len_hi_q, s_data};
            byte_cnt_d = 2'd0;
            state_d    = ({len_hi_q, s_data} == 16'd0) ? ST_WR_COMMIT : ST_GET_DATA;
          end
        end
      end
      ST_WR_DATA: begin
        if (ack_done) begin
          words_d = words_q + 16'd1;
          state_d = ((words_q + 16'd1) == n_q) ? ST_WR_COMMIT : ST_GET_DATA;
        end
      end
      ST_WR_COMMIT: begin
        if (ack_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      error_d = 1'b1;
    end
  end

  // Status outputs are derived from the next state so they line up with
  // the state register.
  assign s_ready_d = (state_d == ST_GET_CTRL) || (state_d == ST_GET_LEN) ||
                     (state_d == ST_GET_DATA);
  assign busy_d    = (state_d != ST_IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'h0;
      len_hi_q   <= 8'h0;
      n_q        <= 16'h0;
      words_q    <= 16'h0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      words_q    <= words_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_wishbone_config_loader.sv
// tb_wishbone_config_loader
// Self-checking bench for wishbone_config_loader. A byte-stream source and
// a Wishbone slave with configurable ack delay run in one negedge monitor;
// expected bus writes are built from the stream format by a small model.
// Build with WB_CONFIG_LOADER_TIMEOUT_EN to exercise the ack timeout.
module tb_wishbone_config_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_addr_o, wbm_data_o;
  logic [31:0] wbm_data_i = 32'hDEAD_BEEF;
  logic        wbm_ack_i;
  logic        busy, done, error;
  logic [15:0] words_written;
  logic        ack_slave = 1'b0;
  logic        ack_spur  = 1'b0;

  assign wbm_ack_i = ack_slave | ack_spur;

  always #5 clk = ~clk;

  wishbone_config_loader #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_addr_o    (wbm_addr_o),
    .wbm_data_o    (wbm_data_o),
    .wbm_data_i    (wbm_data_i),
    .wbm_ack_i     (wbm_ack_i),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] ctrl;
    int          n;
    int          delay;
    bit          rnd;
    int          exp_ww;
    int          exp_writes;
  } vec_t;

  txn_t        got_q[$];
  txn_t        exp_q[$];
  logic [7:0]  src_q[$];
  logic [31:0] load_words[$];

  int checks = 0;
  int failures = 0;

  int done_cnt = 0, err_cnt = 0, bus_err = 0, cyc_idx = 0, consumed = 0;
  int stb_cnt = 0, data_rises = 0, last_stb_len = 0, stb_rise_t = 0, err_t = 0;
  int ack_delay = 1;
  bit slave_en = 1'b1, rnd_valid = 1'b0, prev_ack = 1'b0, xfer_pending = 1'b0;
  logic [31:0] cur_addr = 32'h0, cur_data = 32'h0;
  int done_base = 0, err_base = 0, bus_base = 0, cons_base = 0;

  // Slave, stream source and protocol monitor, all evaluated on the falling
  // edge so every DUT output is stable and driven inputs settle before the
  // next rising edge.
  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (error) begin
      if (err_cnt == err_base) err_t = cyc_idx;
      err_cnt++;
    end
    if (wb_rst_i) begin
      stb_cnt = 0; ack_slave = 1'b0; prev_ack = 1'b0;
    end else if (wbm_stb_o) begin
      if (prev_ack) bus_err++;
      stb_cnt++;
      if (stb_cnt == 1) begin
        cur_addr = wbm_addr_o; cur_data = wbm_data_o; stb_rise_t = cyc_idx;
        if (wbm_addr_o == BASE + 32'd2) data_rises++;
      end else if (wbm_addr_o !== cur_addr || wbm_data_o !== cur_data) begin
        bus_err++;
      end
      if (!wbm_cyc_o || !wbm_we_o || wbm_sel_o !== 4'hF) bus_err++;
      if (s_ready) bus_err++;
      ack_slave = slave_en && (stb_cnt == ack_delay);
      if (ack_slave) begin
        got_q.push_back('{addr: cur_addr, data: cur_data});
        last_stb_len = stb_cnt;
      end
      prev_ack = ack_slave;
    end else begin
      if (wbm_cyc_o) bus_err++;
      stb_cnt = 0; ack_slave = 1'b0; prev_ack = 1'b0;
    end
    if (xfer_pending && src_q.size() > 0) begin
      void'(src_q.pop_front());
      consumed++;
    end
    if (src_q.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
      s_valid = 1'b1; s_data = src_q[0];
    end else begin
      s_valid = 1'b0; s_data = 8'($urandom);
    end
    xfer_pending = s_valid && s_ready && !wb_rst_i;
    cyc_idx++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Serialises one load (control word, length, load_words) into the stream,
  // builds the expected write list, and pulses start.
  task automatic applyStimulus(input logic [31:0] ctrl, input int delay, input bit rnd);
    logic [15:0] nn;
    txn_t t;
    got_q.delete(); exp_q.delete();
    data_rises = 0; ack_delay = delay; rnd_valid = rnd; slave_en = 1'b1;
    nn = 16'(load_words.size());
    for (int b = 3; b >= 0; b--) src_q.push_back(ctrl[8*b +: 8]);
    src_q.push_back(nn[15:8]);
    src_q.push_back(nn[7:0]);
    foreach (load_words[i])
      for (int b = 3; b >= 0; b--) src_q.push_back(load_words[i][8*b +: 8]);
    t.addr = BASE + 32'd1; t.data = ctrl; exp_q.push_back(t);
    foreach (load_words[i]) begin
      t.addr = BASE + 32'd2; t.data = load_words[i]; exp_q.push_back(t);
    end
    t.addr = BASE; t.data = 32'd1; exp_q.push_back(t);
    done_base = done_cnt; err_base = err_cnt; bus_base = bus_err; cons_base = consumed;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 3000) begin
      tick(1);
      k++;
    end
    if (done_cnt == done_base) begin
      checks++; failures++;
      $display("[TB] FAIL %s_done_wait: no done within %0d cycles", tag, k);
    end
    tick(2);
  endtask

  task automatic checkLoad(input string tag, input int exp_ww, input int exp_writes, input int delay);
    int data_acc = 0;
    checkOutput($sformatf("%s_writes", tag), got_q.size(), exp_writes);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
        checkOutput($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
      end
    end
    foreach (got_q[i]) if (got_q[i].addr == BASE + 32'd2) data_acc++;
    checkOutput($sformatf("%s_data_accesses", tag), data_acc, exp_ww);
    checkOutput($sformatf("%s_words_written", tag), {16'h0, words_written}, exp_ww);
    checkOutput($sformatf("%s_done_pulses", tag), done_cnt - done_base, 1);
    checkOutput($sformatf("%s_error_pulses", tag), err_cnt - err_base, 0);
    checkOutput($sformatf("%s_bus_protocol", tag), bus_err - bus_base, 0);
    checkOutput($sformatf("%s_bytes_consumed", tag), consumed - cons_base, 6 + 4 * exp_ww);
    checkOutput($sformatf("%s_stb_len", tag), last_stb_len, delay);
    checkOutput($sformatf("%s_busy", tag), busy, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int k;
    logic [7:0] b0, b1;

    vecs[0] = '{ctrl: 32'h0000_0001, n: 0, delay: 1, rnd: 1'b0, exp_ww: 0, exp_writes: 2};
    vecs[1] = '{ctrl: 32'hDEAD_BEEF, n: 1, delay: 2, rnd: 1'b1, exp_ww: 1, exp_writes: 3};
    vecs[2] = '{ctrl: 32'h1234_5678, n: 3, delay: 7, rnd: 1'b0, exp_ww: 3, exp_writes: 5};
    vecs[3] = '{ctrl: 32'hA5A5_A5A5, n: 5, delay: 3, rnd: 1'b1, exp_ww: 5, exp_writes: 7};
    vecs[4] = '{ctrl: 32'hFFFF_FFFF, n: 4, delay: 1, rnd: 1'b1, exp_ww: 4, exp_writes: 6};

    // Reset values
    tick(3);
    checkOutput("rst_cyc", wbm_cyc_o, 0);
    checkOutput("rst_stb", wbm_stb_o, 0);
    checkOutput("rst_we", wbm_we_o, 0);
    checkOutput("rst_sel", wbm_sel_o, 0);
    checkOutput("rst_addr", wbm_addr_o, 0);
    checkOutput("rst_data", wbm_data_o, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_words", {16'h0, words_written}, 0);
    wb_rst_i = 1'b0;
    tick(2);

    // Nominal load with the reference byte sequence
    load_words = {32'h0FAA_55F0, 32'hF055_AA0F};
    applyStimulus(32'h0304_05FF, 1, 1'b0);
    waitDone("nominal");
    checkLoad("nominal", 2, 4, 1);
    if (got_q.size() == 4) begin
      checkOutput("nominal_w0_addr", got_q[0].addr, 32'h3000_0001);
      checkOutput("nominal_w0_data", got_q[0].data, 32'h0304_05FF);
      checkOutput("nominal_w1_data", got_q[1].data, 32'h0FAA_55F0);
      checkOutput("nominal_w2_data", got_q[2].data, 32'hF055_AA0F);
      checkOutput("nominal_w3_addr", got_q[3].addr, 32'h3000_0000);
      checkOutput("nominal_w3_data", got_q[3].data, 32'h0000_0001);
    end

    // Spurious ack while idle
    ack_spur = 1'b1; tick(1); ack_spur = 1'b0; tick(2);
    checkOutput("spur_idle_busy", busy, 0);
    checkOutput("spur_idle_cyc", wbm_cyc_o, 0);
    checkOutput("spur_idle_words", {16'h0, words_written}, 2);
    checkOutput("spur_idle_done", done_cnt - done_base, 1);

    // Spurious ack while waiting for data bytes
    load_words = {32'h1357_9BDF};
    applyStimulus(32'h0000_00C3, 2, 1'b0);
    b1 = src_q.pop_back();
    b0 = src_q.pop_back();
    k = 0;
    while (src_q.size() != 0 && k < 200) begin tick(1); k++; end
    tick(3);
    checkOutput("spur_data_ctrl_written", got_q.size(), 1);
    checkOutput("spur_data_s_ready", s_ready, 1);
    checkOutput("spur_data_busy_pre", busy, 1);
    ack_spur = 1'b1; tick(1); ack_spur = 1'b0; tick(2);
    checkOutput("spur_data_words", {16'h0, words_written}, 0);
    checkOutput("spur_data_cyc", wbm_cyc_o, 0);
    checkOutput("spur_data_writes", got_q.size(), 1);
    checkOutput("spur_data_busy", busy, 1);
    src_q.push_back(b0);
    src_q.push_back(b1);
    waitDone("spur_data");
    checkLoad("spur_data", 1, 3, 2);

    // Reset during the second data write
    load_words = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    applyStimulus(32'hCAFE_0001, 4, 1'b0);
    k = 0;
    while (!(data_rises == 2 && wbm_stb_o) && k < 2000) begin tick(1); k++; end
    checkOutput("midrst_reached_2nd_data", data_rises, 2);
    wb_rst_i = 1'b1;
    tick(1);
    checkOutput("midrst_cyc", wbm_cyc_o, 0);
    checkOutput("midrst_stb", wbm_stb_o, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_words", {16'h0, words_written}, 0);
    src_q.delete();
    wb_rst_i = 1'b0;
    tick(6);
    checkOutput("midrst_no_done", done_cnt - done_base, 0);

    // Table-driven loads, including N=0 and a 7-cycle slave with s_valid held high
    for (int v = 0; v < 5; v++) begin
      load_words.delete();
      for (int w = 0; w < vecs[v].n; w++) load_words.push_back($urandom);
      applyStimulus(vecs[v].ctrl, vecs[v].delay, vecs[v].rnd);
      waitDone($sformatf("vec%0d", v));
      checkLoad($sformatf("vec%0d", v), vecs[v].exp_ww, vecs[v].exp_writes, vecs[v].delay);
    end

    // Randomised loads
    for (int r = 0; r < 4; r++) begin
      int n, d;
      n = int'($urandom_range(0, 6));
      d = int'($urandom_range(1, 5));
      load_words.delete();
      for (int w = 0; w < n; w++) load_words.push_back($urandom);
      applyStimulus($urandom, d, 1'b1);
      waitDone($sformatf("rand%0d", r));
      checkLoad($sformatf("rand%0d", r), n, n + 2, d);
    end

    // Slave that never acknowledges
    load_words = {32'h0BAD_F00D};
`ifdef WB_CONFIG_LOADER_TIMEOUT_EN
    applyStimulus(32'h0BAD_0001, 1, 1'b0);
    slave_en = 1'b0;
    k = 0;
    while (err_cnt == err_base && k < 300) begin tick(1); k++; end
    checkOutput("tmo_error_pulses", err_cnt - err_base, 1);
    checkOutput("tmo_latency", err_t - stb_rise_t, TMO);
    checkOutput("tmo_stb", wbm_stb_o, 0);
    checkOutput("tmo_cyc", wbm_cyc_o, 0);
    checkOutput("tmo_busy", busy, 0);
    tick(1);
    checkOutput("tmo_error_width", error, 0);
    checkOutput("tmo_no_done", done_cnt - done_base, 0);
    checkOutput("tmo_no_writes", got_q.size(), 0);
    src_q.delete();
    slave_en = 1'b1;
    tick(2);
`else
    applyStimulus(32'h0BAD_0001, 1, 1'b0);
    slave_en = 1'b0;
    tick(60);
    checkOutput("noack_no_error", err_cnt - err_base, 0);
    checkOutput("noack_stb_held", wbm_stb_o, 1);
    checkOutput("noack_busy", busy, 1);
    checkOutput("noack_no_writes", got_q.size(), 0);
    wb_rst_i = 1'b1;
    tick(2);
    src_q.delete();
    wb_rst_i = 1'b0;
    slave_en = 1'b1;
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
